// File: rtl/cordic_add_subt_fx_if.sv
// Request/ready/ack handshake and operand/result bus between the CORDIC control FSM and its adder/subtractor.
interface cordic_add_subt_fx_if #(
    parameter int unsigned W = 32
);
    logic         beg_add_subt;
    logic         ack_add_subt;
    logic         add_subt;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic         ready_add_subt;
    logic         busy;
    logic [W-1:0] result;
    logic         overflow_flag;

    modport master (
        output beg_add_subt, ack_add_subt, add_subt, data_a, data_b,
        input  ready_add_subt, busy, result, overflow_flag
    );

    modport slave (
        input  beg_add_subt, ack_add_subt, add_subt, data_a, data_b,
        output ready_add_subt, busy, result, overflow_flag
    );
endinterface

// File: rtl/cordic_add_subt_fx.sv
// Multi-cycle two's-complement add/subtract for CORDIC X/Y/Z updates, three edges from start to ready.
// Define CORDIC_ADDSUBT_SAT_EN to saturate on overflow; otherwise the result wraps.
module cordic_add_subt_fx #(
    parameter int unsigned W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    cordic_add_subt_fx_if.slave  bus
);
    localparam int unsigned WS = W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t       state;
    logic         beg_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         op_q;
    logic [W:0]   sum_q;
    logic [W-1:0] result_q;
    logic         ovf_q;
    logic         ready_q;
    logic         busy_q;

    logic [W:0]   a_ext_c;
    logic [W:0]   b_ext_c;
    logic [W:0]   b_eff_c;
    logic [W:0]   sum_c;
    logic         ovf_c;
    logic [W-1:0] res_c;
    logic         start_c;

    // Negate at W+1 bits so that subtracting the most negative value keeps its true sign.
    always_comb begin
        a_ext_c = {a_q[W-1], a_q};
        b_ext_c = {b_q[W-1], b_q};
        b_eff_c = op_q ? (~b_ext_c + WS'(1)) : b_ext_c;
        sum_c   = a_ext_c + b_eff_c;
    end

    // Overflow when the extension bit disagrees with the W-bit sign.
    always_comb begin
        ovf_c = sum_q[W] ^ sum_q[W-1];
`ifdef CORDIC_ADDSUBT_SAT_EN
        if (!ovf_c)
            res_c = sum_q[W-1:0];
        else if (sum_q[W])
            res_c = {1'b1, {(W-1){1'b0}}};
        else
            res_c = {1'b0, {(W-1){1'b1}}};
`else
        res_c = sum_q[W-1:0];
`endif
    end

    assign start_c = bus.beg_add_subt & ~beg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            beg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            sum_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            beg_q <= bus.beg_add_subt;
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (start_c) begin
                        a_q    <= bus.data_a;
                        b_q    <= bus.data_b;
                        op_q   <= bus.add_subt;
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    sum_q <= sum_c;
                    state <= CALC;
                end
                CALC: begin
                    result_q <= res_c;
                    ovf_q    <= ovf_c;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    // Leaving on beg low as well as ack keeps a held request from restarting.
                    if (bus.ack_add_subt || !bus.beg_add_subt) begin
                        ready_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_add_subt = ready_q;
    assign bus.busy           = busy_q;
    assign bus.result         = result_q;
    assign bus.overflow_flag  = ovf_q;
endmodule

// File: tb/tb_cordic_add_subt_fx.sv
// Scoreboard bench for cordic_add_subt_fx: directed vectors queue expectations, a monitor checks each ready rise.
module tb_cordic_add_subt_fx;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cordic_add_subt_fx_if #(.W(32)) bus ();

    cordic_add_subt_fx #(.W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

`ifdef CORDIC_ADDSUBT_SAT_EN
    localparam logic [31:0] POS_OVF_R  = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_OVF_R  = 32'h8000_0000;
    localparam logic [31:0] NEG_B_R    = 32'h7FFF_FFFF;
    localparam logic [31:0] MIN_MIN_R  = 32'h8000_0000;
`else
    localparam logic [31:0] POS_OVF_R  = 32'h9000_0000;
    localparam logic [31:0] NEG_OVF_R  = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_B_R    = 32'h8000_0000;
    localparam logic [31:0] MIN_MIN_R  = 32'h0000_0000;
`endif

    typedef struct {
        logic [31:0] r;
        logic        o;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    logic ready_d = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endfunction

    // Monitor: one scoreboard pop per rising ready.
    always @(negedge clk) begin
        if (reset && bus.ready_add_subt && !ready_d) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 32'(bus.ready_add_subt), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_result"}, bus.result, mon_e.r);
                chk({mon_e.name, "_ovf"}, 32'(bus.overflow_flag), 32'(mon_e.o));
            end
        end
        ready_d = reset & bus.ready_add_subt;
    end

    // Issue one request from a negedge; waits for ready, then drops beg and checks ready falls.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] er, input logic eo,
                          input int change_at, input int drop_at);
        int n;
        n = 0;
        exp_q.push_back('{r: er, o: eo, name: name});
        bus.data_a       = a;
        bus.data_b       = b;
        bus.add_subt     = sub;
        bus.beg_add_subt = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == change_at) begin
                bus.data_a   = 32'd100;
                bus.add_subt = ~sub;
            end
            if (n == drop_at) bus.beg_add_subt = 1'b0;
        end while (!bus.ready_add_subt && n < 20);
        chk({name, "_latency"}, 32'(n), 32'd3);
        bus.beg_add_subt = 1'b0;
        @(negedge clk);
        chk({name, "_ready_drop"}, 32'(bus.ready_add_subt), 32'd0);
    endtask

    initial begin
        int n;
        reset            = 1'b0;
        bus.beg_add_subt = 1'b0;
        bus.ack_add_subt = 1'b0;
        bus.add_subt     = 1'b0;
        bus.data_a       = '0;
        bus.data_b       = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready_add_subt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_ovf", 32'(bus.overflow_flag), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("add",     32'h3000_0000, 32'h2000_0000, 1'b0, 32'h5000_0000, 1'b0, 0, 0);
        run_op("pos_ovf", 32'h6000_0000, 32'h3000_0000, 1'b0, POS_OVF_R,     1'b1, 0, 0);
        repeat (3) @(negedge clk);
        chk("idle_hold_result", bus.result, POS_OVF_R);
        chk("idle_hold_ovf", 32'(bus.overflow_flag), 32'd1);

        // Reset while in CALC: no ready may follow, outputs cleared.
        bus.data_a = 32'h0000_0011; bus.data_b = 32'h0000_0022; bus.add_subt = 1'b0;
        bus.beg_add_subt = 1'b1;
        repeat (2) @(negedge clk);
        chk("midop_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("midop_rst_ready", 32'(bus.ready_add_subt), 32'd0);
        chk("midop_rst_result", bus.result, 32'd0);
        chk("midop_rst_ovf", 32'(bus.overflow_flag), 32'd0);
        chk("midop_rst_busy", 32'(bus.busy), 32'd0);
        bus.beg_add_subt = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midop_no_ready", 32'(bus.ready_add_subt), 32'd0);

        run_op("neg_ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b1, NEG_OVF_R, 1'b1, 0, 0);
        run_op("sub_min",     32'h0000_0000, 32'h8000_0000, 1'b1, NEG_B_R,   1'b1, 0, 0);
        run_op("add_min_min", 32'h8000_0000, 32'h8000_0000, 1'b0, MIN_MIN_R, 1'b1, 0, 0);
        run_op("opnd_change", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1, 0);
        run_op("beg_drop",    32'hFFFF_FFFD, 32'h0000_0010, 1'b0, 32'h0000_000D, 1'b0, 0, 1);

        // Held request with no ack: ready stays up, no second operation.
        exp_q.push_back('{r: 32'h2345_6789, o: 1'b0, name: "hold"});
        bus.data_a = 32'h1234_5678; bus.data_b = 32'h1111_1111; bus.add_subt = 1'b0;
        bus.beg_add_subt = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ready_add_subt && n < 20);
        chk("hold_latency", 32'(n), 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_ready", 32'(bus.ready_add_subt), 32'd1);
        end
        chk("hold_busy", 32'(bus.busy), 32'd0);
        bus.ack_add_subt = 1'b1;
        @(negedge clk);
        chk("ack_ready_drop", 32'(bus.ready_add_subt), 32'd0);
        bus.ack_add_subt = 1'b0;
        repeat (4) @(negedge clk);
        chk("ack_no_restart_busy", 32'(bus.busy), 32'd0);
        chk("ack_no_restart_ready", 32'(bus.ready_add_subt), 32'd0);
        bus.beg_add_subt = 1'b0;
        @(negedge clk);
        run_op("restart_sub", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cordic_add_subt_fx.md
Name: cordic_add_subt_fx

Overview:
- Multi-cycle fixed-point two's-complement adder/subtractor serving the CORDIC control FSM. Computes X/Y/Z iteration updates.
- The FSM raises beg_add_subt and holds it until ready_add_subt is seen. The result goes to the Xn/Yn/Zn registers.
- Registered operands and result, with saturation on overflow. The request/ready/ack handshake gives exactly one operation per request.

Parameters:
- W, 32, operand and result width in bits (two's complement; binary point position is irrelevant to this block).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- beg_add_subt  input  1  operation request; level held by requester until ready_add_subt is observed.
- ack_add_subt  input  1  requester has consumed result.
- add_subt  input  1  0 = data_a + data_b, 1 = data_a - data_b.
- data_a  input  W  first operand.
- data_b  input  W  second operand.
- ready_add_subt  output  1  result valid.
- busy  output  1  operation in progress (states LOAD/CALC).
- result  output  W  registered result.
- overflow_flag  output  1  result of the last operation exceeded W-bit signed range.

Behaviour:
- Reset: async on reset=0.
  - State goes to IDLE; result=0, overflow_flag=0, ready_add_subt=0, busy=0.
  - Internal operand regs and beg edge-detect reg are cleared.
  - Reset mid-operation aborts the operation; no ready is issued afterwards.
- Start detection: beg_q registers beg_add_subt every cycle. A start is beg_add_subt=1 and beg_q=0, sampled in IDLE. Level-high beg persisting after completion does not restart the block.
- FSM states (all outputs Moore-decoded from registered state/data):
  - IDLE: ready=0, busy=0. On start: capture data_a, data_b, add_subt into internal regs; -> LOAD.
  - LOAD: busy=1. Form b_eff = add_subt ? ~b + 1 : b. Register sign-extended (W+1)-bit sum a + b_eff; -> CALC.
  - CALC: busy=1. Overflow when bit W differs from bit W-1 of sum.
    - Positive overflow (bit W=0): result=2^(W-1)-1.
    - Negative overflow (bit W=1): result=-2^(W-1).
    - Otherwise: result=sum[W-1:0].
    - Register result and overflow_flag; -> DONE.
  - DONE: ready=1.
    - If ack_add_subt=1 or beg_add_subt=0: -> IDLE (ready drops the next cycle).
    - Otherwise stay in DONE.
- Latency: the start is sampled at edge E0. ready_add_subt=1 and result valid immediately after edge E2 (3 clock edges including E0).
- Subtract of b = -2^(W-1): two's-complement negation wraps. Full-width (W+1) arithmetic must still give the correct sign, e.g. 0 - 0x80000000 -> positive overflow, saturate.
- Operand/add_subt changes after the start edge are ignored.
- result and overflow_flag hold their value in IDLE until the next CALC update.
- ack_add_subt outside DONE is ignored.
- beg dropping during LOAD/CALC does not abort. The block still reaches DONE. ready asserts for one cycle, then returns to IDLE because beg=0.
- Simultaneous ack=1 and beg=1 in DONE: -> IDLE. A new start requires beg low then high again.

Optional Feature:
- CORDIC_ADDSUBT_SAT_EN.
- Defined: saturation as in CALC above.
- Undefined: result = sum[W-1:0] (wrap-around).
- In both cases: overflow_flag is still computed and registered, and latency and handshake are unchanged.

Test Plan:
- Reset mid-op: assert reset=0 during CALC -> ready=0, result=0, state IDLE; next request completes normally.
- Add, W=32: a=0x30000000, b=0x20000000, add_subt=0, beg rises -> ready=1 after 3rd edge, result=0x50000000, overflow=0; drop beg -> ready=0 next cycle.
- Positive overflow: a=0x60000000 + b=0x30000000 -> overflow=1; result=0x7FFFFFFF with SAT_EN, 0x90000000 without.
- Negative overflow on subtract: a=0x80000000 - b=0x00000001 -> overflow=1; result=0x80000000 with SAT_EN, 0x7FFFFFFF without. Also 0x00000000 - 0x80000000 -> overflow=1, 0x7FFFFFFF with SAT_EN.
- Handshake hold: beg held high 10 cycles, ack=0 -> ready stays 1 through cycle 10, no second operation.
  - Then ack=1 with beg=1 -> IDLE, no restart.
  - beg low 1 cycle then high with a=5, b=7, add_subt=1 -> result=0xFFFFFFFE.
- Operand change: start with a=1, b=2; change a to 100 during LOAD -> result=3.
